// File: rtl/if_id_pkg.sv
// Shared types and reset/bubble constants for the IF/ID pipeline boundary.
package if_id_pkg;

    localparam logic [31:0] IF_ID_PC_RESET    = 32'h0000_0020;
    localparam logic [15:0] IF_ID_RESET_INSTR = 16'h5790;
    localparam logic [15:0] IF_ID_NOP         = 16'h5000;

    typedef struct packed {
        logic [31:0] pc;
        logic [15:0] instr;
        logic [15:0] port;
    } if_id_beat_t;

endpackage

// File: rtl/if_id_beat_reg.sv
// One beat-wide register with valid bit; a constant load (reset/bubble) beats
// a normal load, which beats a clear.
module if_id_beat_reg
    import if_id_pkg::*;
#(
    parameter int         W     = 64,
    parameter logic [W-1:0] RST_D = '0,
    parameter logic       RST_V = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         load_const,
    input  logic         clear,
    input  logic [W-1:0] d,
    input  logic [W-1:0] const_d,
    output logic         valid,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= RST_V;
            q     <= RST_D;
        end else if (load_const) begin
            valid <= 1'b1;
            q     <= const_d;
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/if_id_skid_stage.sv
// IF/ID boundary with a 2-entry skid so in_ready depends only on registered
// state and en; supports flush-to-bubble and a global enable.
module if_id_skid_stage
    import if_id_pkg::*;
#(
    parameter int                PC_W         = 32,
    parameter int                INSTR_W      = 16,
    parameter int                PORT_W       = 16,
    parameter logic [PC_W-1:0]    PC_RESET     = IF_ID_PC_RESET,
    parameter logic [INSTR_W-1:0] RESET_INSTR  = IF_ID_RESET_INSTR,
    parameter logic [INSTR_W-1:0] NOP_INSTR    = IF_ID_NOP,
    parameter bit                FLUSH_BUBBLE = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [PORT_W-1:0]  in_port,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    out_pc,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PORT_W-1:0]  out_port,
    output logic [1:0]         occupancy
);

    localparam int BEAT_W = PC_W + INSTR_W + PORT_W;
    localparam logic [BEAT_W-1:0] M_RST = {PC_RESET, RESET_INSTR, {PORT_W{1'b0}}};

    logic              m_valid, s_valid;
    logic [BEAT_W-1:0] m_q, s_q, in_beat, bubble_beat, m_d;
    logic              accept, drain, m_free;
    logic              m_load, m_load_const, m_clear;
    logic              s_load, s_clear;

    assign in_beat     = {in_pc, in_instr, in_port};
    assign bubble_beat = {in_pc, NOP_INSTR, {PORT_W{1'b0}}};

    assign in_ready  = en & ~s_valid;
    assign accept    = in_valid & in_ready & ~flush;
    assign drain     = m_valid & out_ready & en;
    assign m_free    = ~m_valid | drain;
    assign m_d       = s_valid ? s_q : in_beat;

    // Flush outranks normal traffic; S always refills M before a new beat can.
    always_comb begin
        m_load       = 1'b0;
        m_load_const = 1'b0;
        m_clear      = 1'b0;
        s_load       = 1'b0;
        s_clear      = 1'b0;
        if (en) begin
            if (flush) begin
                m_load_const = FLUSH_BUBBLE;
                m_clear      = ~FLUSH_BUBBLE;
                s_clear      = 1'b1;
            end else if (m_free) begin
                m_load  = s_valid | accept;
                m_clear = ~s_valid & ~accept;
                s_clear = s_valid;
            end else begin
                s_load = accept;
            end
        end
    end

    if_id_beat_reg #(
        .W     (BEAT_W),
        .RST_D (M_RST),
        .RST_V (1'b1)
    ) u_main (
        .clk        (clk),
        .rst        (rst),
        .load       (m_load),
        .load_const (m_load_const),
        .clear      (m_clear),
        .d          (m_d),
        .const_d    (bubble_beat),
        .valid      (m_valid),
        .q          (m_q)
    );

    if_id_beat_reg #(
        .W     (BEAT_W),
        .RST_D ('0),
        .RST_V (1'b0)
    ) u_skid (
        .clk        (clk),
        .rst        (rst),
        .load       (s_load),
        .load_const (1'b0),
        .clear      (s_clear),
        .d          (in_beat),
        .const_d    ({BEAT_W{1'b0}}),
        .valid      (s_valid),
        .q          (s_q)
    );

    assign out_valid = m_valid;
    assign out_pc    = m_q[BEAT_W-1 -: PC_W];
    assign out_instr = m_q[PORT_W +: INSTR_W];
    assign out_port  = m_q[PORT_W-1:0];
    assign occupancy = {1'b0, m_valid} + {1'b0, s_valid};

endmodule

// File: tb/tb_if_id_skid_stage.sv
// Directed self-checking bench for if_id_skid_stage: reset, streaming,
// backpressure, flush, enable freeze and reset-over-flush.
module tb_if_id_skid_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_pc = '0;
    logic [15:0] in_instr = '0;
    logic [15:0] in_port = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [15:0] out_instr;
    logic [15:0] out_port;
    logic [1:0]  occupancy;

    int compared = 0;
    int mismatched = 0;

    if_id_skid_stage dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .in_port   (in_port),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .out_port  (out_port),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    // Advance one edge; outputs are sampled and inputs changed 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [15:0] ins,
                         input logic [15:0] prt);
        in_valid = v;
        in_pc    = pc;
        in_instr = ins;
        in_port  = prt;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 32'h0, 16'h0, 16'h0);
        step();
        step();
        rst = 1'b0;
        #1;
        compared++; if (out_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_valid got %b exp 1", out_valid); end
        compared++; if (out_pc !== 32'h20) begin mismatched++; $display("[TB] FAIL reset_pc got %h exp 00000020", out_pc); end
        compared++; if (out_instr !== 16'h5790) begin mismatched++; $display("[TB] FAIL reset_instr got %h exp 5790", out_instr); end
        compared++; if (out_port !== 16'h0) begin mismatched++; $display("[TB] FAIL reset_port got %h exp 0000", out_port); end
        compared++; if (in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_in_ready got %b exp 1", in_ready); end
        compared++; if (occupancy !== 2'd1) begin mismatched++; $display("[TB] FAIL reset_occ got %0d exp 1", occupancy); end
    endtask

    task automatic test_stream();
        logic [31:0] pcs [3];
        pcs[0] = 32'h40; pcs[1] = 32'h42; pcs[2] = 32'h44;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, pcs[i], 16'h1100 + 16'(i), 16'hA000 + 16'(i));
            step();
            compared++; if (out_pc !== pcs[i]) begin mismatched++; $display("[TB] FAIL stream_pc%0d got %h exp %h", i, out_pc, pcs[i]); end
            compared++; if (out_instr !== 16'h1100 + 16'(i)) begin mismatched++; $display("[TB] FAIL stream_instr%0d got %h exp %h", i, out_instr, 16'h1100 + 16'(i)); end
            compared++; if (out_port !== 16'hA000 + 16'(i)) begin mismatched++; $display("[TB] FAIL stream_port%0d got %h exp %h", i, out_port, 16'hA000 + 16'(i)); end
            compared++; if (occupancy !== 2'd1) begin mismatched++; $display("[TB] FAIL stream_occ%0d got %0d exp 1", i, occupancy); end
            compared++; if (in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL stream_ready%0d got %b exp 1", i, in_ready); end
        end
        drive(1'b0, 32'h0, 16'h0, 16'h0);
        step();
        compared++; if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL stream_empty_valid got %b exp 0", out_valid); end
        compared++; if (occupancy !== 2'd0) begin mismatched++; $display("[TB] FAIL stream_empty_occ got %0d exp 0", occupancy); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(1'b1, 32'h40, 16'h2222, 16'h0001);
        step();
        compared++; if (occupancy !== 2'd1) begin mismatched++; $display("[TB] FAIL bp_occ1 got %0d exp 1", occupancy); end
        drive(1'b1, 32'h42, 16'h2224, 16'h0002);
        step();
        compared++; if (occupancy !== 2'd2) begin mismatched++; $display("[TB] FAIL bp_occ2 got %0d exp 2", occupancy); end
        compared++; if (in_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL bp_ready_low got %b exp 0", in_ready); end
        compared++; if (out_pc !== 32'h40) begin mismatched++; $display("[TB] FAIL bp_head_pc got %h exp 00000040", out_pc); end
        drive(1'b1, 32'h99, 16'h9999, 16'h0009);
        step();
        compared++; if (occupancy !== 2'd2) begin mismatched++; $display("[TB] FAIL bp_hold_occ got %0d exp 2", occupancy); end
        compared++; if (out_pc !== 32'h40) begin mismatched++; $display("[TB] FAIL bp_hold_pc got %h exp 00000040", out_pc); end
        drive(1'b0, 32'h0, 16'h0, 16'h0);
        out_ready = 1'b1;
        step();
        compared++; if (out_pc !== 32'h42) begin mismatched++; $display("[TB] FAIL bp_second_pc got %h exp 00000042", out_pc); end
        compared++; if (out_instr !== 16'h2224) begin mismatched++; $display("[TB] FAIL bp_second_instr got %h exp 2224", out_instr); end
        compared++; if (occupancy !== 2'd1) begin mismatched++; $display("[TB] FAIL bp_resume_occ got %0d exp 1", occupancy); end
        compared++; if (in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL bp_resume_ready got %b exp 1", in_ready); end
        step();
        compared++; if (occupancy !== 2'd0) begin mismatched++; $display("[TB] FAIL bp_drained_occ got %0d exp 0", occupancy); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(1'b1, 32'h60, 16'h3330, 16'h0060);
        step();
        drive(1'b1, 32'h62, 16'h3332, 16'h0062);
        step();
        compared++; if (occupancy !== 2'd2) begin mismatched++; $display("[TB] FAIL flush_pre_occ got %0d exp 2", occupancy); end
        flush = 1'b1;
        drive(1'b1, 32'h50, 16'h7777, 16'hBEEF);
        step();
        flush = 1'b0;
        drive(1'b0, 32'h0, 16'h0, 16'h0);
        compared++; if (out_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL flush_valid got %b exp 1", out_valid); end
        compared++; if (out_instr !== 16'h5000) begin mismatched++; $display("[TB] FAIL flush_instr got %h exp 5000", out_instr); end
        compared++; if (out_pc !== 32'h50) begin mismatched++; $display("[TB] FAIL flush_pc got %h exp 00000050", out_pc); end
        compared++; if (out_port !== 16'h0) begin mismatched++; $display("[TB] FAIL flush_port got %h exp 0000", out_port); end
        compared++; if (occupancy !== 2'd1) begin mismatched++; $display("[TB] FAIL flush_occ got %0d exp 1", occupancy); end
        out_ready = 1'b1;
        step();
        compared++; if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL flush_nodup_valid got %b exp 0", out_valid); end
        compared++; if (occupancy !== 2'd0) begin mismatched++; $display("[TB] FAIL flush_nodup_occ got %0d exp 0", occupancy); end
    endtask

    task automatic test_enable();
        out_ready = 1'b0;
        drive(1'b1, 32'h70, 16'h4440, 16'h0070);
        step();
        compared++; if (out_pc !== 32'h70) begin mismatched++; $display("[TB] FAIL en_pre_pc got %h exp 00000070", out_pc); end
        en = 1'b0;
        out_ready = 1'b1;
        drive(1'b1, 32'h74, 16'h4444, 16'h0074);
        #1;
        compared++; if (in_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL en_ready_comb got %b exp 0", in_ready); end
        for (int i = 0; i < 3; i++) begin
            flush = (i == 2);
            step();
            compared++; if (out_pc !== 32'h70) begin mismatched++; $display("[TB] FAIL en_freeze_pc%0d got %h exp 00000070", i, out_pc); end
            compared++; if (out_instr !== 16'h4440) begin mismatched++; $display("[TB] FAIL en_freeze_instr%0d got %h exp 4440", i, out_instr); end
            compared++; if (occupancy !== 2'd1) begin mismatched++; $display("[TB] FAIL en_freeze_occ%0d got %0d exp 1", i, occupancy); end
            compared++; if (in_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL en_freeze_ready%0d got %b exp 0", i, in_ready); end
        end
        flush = 1'b0;
        en = 1'b1;
        drive(1'b0, 32'h0, 16'h0, 16'h0);
        step();
        compared++; if (occupancy !== 2'd0) begin mismatched++; $display("[TB] FAIL en_resume_occ got %0d exp 0", occupancy); end
    endtask

    task automatic test_reset_flush();
        out_ready = 1'b0;
        drive(1'b1, 32'h80, 16'h5550, 16'h0080);
        step();
        drive(1'b1, 32'h82, 16'h5552, 16'h0082);
        step();
        compared++; if (occupancy !== 2'd2) begin mismatched++; $display("[TB] FAIL rf_pre_occ got %0d exp 2", occupancy); end
        rst = 1'b1;
        flush = 1'b1;
        drive(1'b1, 32'h90, 16'h6666, 16'h0090);
        step();
        rst = 1'b0;
        flush = 1'b0;
        drive(1'b0, 32'h0, 16'h0, 16'h0);
        compared++; if (out_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL rf_valid got %b exp 1", out_valid); end
        compared++; if (out_pc !== 32'h20) begin mismatched++; $display("[TB] FAIL rf_pc got %h exp 00000020", out_pc); end
        compared++; if (out_instr !== 16'h5790) begin mismatched++; $display("[TB] FAIL rf_instr got %h exp 5790", out_instr); end
        compared++; if (out_port !== 16'h0) begin mismatched++; $display("[TB] FAIL rf_port got %h exp 0000", out_port); end
        compared++; if (occupancy !== 2'd1) begin mismatched++; $display("[TB] FAIL rf_occ got %0d exp 1", occupancy); end
        compared++; if (in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL rf_ready got %b exp 1", in_ready); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_enable();
        test_reset_flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
